// File: rtl/spi_frame_reader.sv
// SPI mode-0 master that reads one mic-array frame: a discarded pipeline byte followed
// by NUM_MICS PCM bytes, presented on a valid/ready stream tagged with mic index.
module spi_frame_reader #(
  parameter int NUM_MICS  = 25,
  parameter int SCK_DIV   = 4,
  parameter int SETUP_CYC = 8,
  parameter int GAP_CYC   = 16,
  parameter int IDX_W     = (NUM_MICS > 1) ? $clog2(NUM_MICS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             ssel,
  output logic             sck,
  output logic             mosi,
  input  logic             miso,
  output logic [7:0]       out_data,
  output logic [IDX_W-1:0] out_mic,
  output logic             out_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             frame_done
);

  localparam int CNT_MAX = (SETUP_CYC > GAP_CYC)
                           ? ((SETUP_CYC > SCK_DIV) ? SETUP_CYC : SCK_DIV)
                           : ((GAP_CYC > SCK_DIV) ? GAP_CYC : SCK_DIV);
  localparam int CNT_W  = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int BYTE_W = $clog2(NUM_MICS + 1);

  localparam logic [CNT_W-1:0]  SETUP_LAST = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0]  HALF_LAST  = CNT_W'(SCK_DIV - 1);
  localparam logic [CNT_W-1:0]  GAP_LAST   = CNT_W'(GAP_CYC - 1);
  localparam logic [BYTE_W-1:0] LAST_BYTE  = BYTE_W'(NUM_MICS);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD, S_DONE, S_GAP} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [2:0]        bit_cnt, bit_cnt_nxt;
  logic [BYTE_W-1:0] byte_cnt, byte_cnt_nxt;
  logic              sck_nxt, ssel_nxt, busy_nxt, valid_nxt, frame_done_nxt;
  logic              shift_in, load_out, launch, out_free;
  logic [7:0]        shreg;

  assign mosi     = 1'b0;
  assign out_free = ~out_valid | out_ready;
  // The last gap cycle doubles as IDLE so held start gives exactly GAP_CYC high cycles.
  assign launch   = start & ((state == S_IDLE) | ((state == S_GAP) & (cnt == GAP_LAST)));

  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    bit_cnt_nxt    = bit_cnt;
    byte_cnt_nxt   = byte_cnt;
    sck_nxt        = sck;
    ssel_nxt       = ssel;
    busy_nxt       = busy;
    valid_nxt      = out_valid & ~out_ready;
    frame_done_nxt = 1'b0;
    shift_in       = 1'b0;
    load_out       = 1'b0;
    case (state)
      S_SETUP: begin
        if (cnt == SETUP_LAST) begin
          cnt_nxt   = '0;
          state_nxt = S_SHIFT;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      S_SHIFT: begin
        // Divider is frozen while the previous byte still sits unaccepted in the output register.
        if (out_free) begin
          if (cnt == HALF_LAST) begin
            cnt_nxt = '0;
            sck_nxt = ~sck;
            if (!sck) begin
              shift_in = 1'b1;
            end else if (bit_cnt == 3'd7) begin
              bit_cnt_nxt = '0;
              state_nxt   = S_HOLD;
            end else begin
              bit_cnt_nxt = bit_cnt + 3'd1;
            end
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
      end
      S_HOLD: begin
        byte_cnt_nxt = byte_cnt + 1'b1;
        if (byte_cnt != '0) begin
          load_out  = 1'b1;
          valid_nxt = 1'b1;
        end
        state_nxt = (byte_cnt == LAST_BYTE) ? S_DONE : S_SHIFT;
      end
      S_DONE: begin
        if (out_free) begin
          ssel_nxt       = 1'b1;
          frame_done_nxt = 1'b1;
          cnt_nxt        = '0;
          state_nxt      = S_GAP;
        end
      end
      S_GAP: begin
        if (cnt == GAP_LAST) begin
          cnt_nxt   = '0;
          busy_nxt  = 1'b0;
          state_nxt = S_IDLE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
      end
    endcase
    if (launch) begin
      state_nxt    = (SETUP_CYC == 0) ? S_SHIFT : S_SETUP;
      cnt_nxt      = '0;
      bit_cnt_nxt  = '0;
      byte_cnt_nxt = '0;
      ssel_nxt     = 1'b0;
      busy_nxt     = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      bit_cnt    <= '0;
      byte_cnt   <= '0;
      sck        <= 1'b0;
      ssel       <= 1'b1;
      busy       <= 1'b0;
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      bit_cnt    <= bit_cnt_nxt;
      byte_cnt   <= byte_cnt_nxt;
      sck        <= sck_nxt;
      ssel       <= ssel_nxt;
      busy       <= busy_nxt;
      out_valid  <= valid_nxt;
      frame_done <= frame_done_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (shift_in) shreg <= {shreg[6:0], miso};
  end

  // Output register: mic index is one behind byte_cnt because byte 0 is the dummy.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data <= '0;
      out_mic  <= '0;
      out_last <= 1'b0;
    end else if (load_out) begin
      out_data <= shreg;
      out_mic  <= IDX_W'(byte_cnt - 1'b1);
      out_last <= (byte_cnt == LAST_BYTE);
    end
  end

endmodule

// File: tb/tb_spi_frame_reader.sv
// Directed bench for spi_frame_reader with a behavioural mode-0 slave and stream monitor.
module tb_spi_frame_reader;
  localparam int NM   = 25;
  localparam int SD   = 2;
  localparam int SU   = 8;
  localparam int GP   = 16;
  localparam int IW   = $clog2(NM);
  localparam int SLOT = 16 * SD + 1;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, miso = 1'b0, out_ready = 1'b1;
  logic busy, ssel, sck, mosi, out_last, out_valid, frame_done;
  logic [7:0]    out_data;
  logic [IW-1:0] out_mic;

  spi_frame_reader #(.NUM_MICS(NM), .SCK_DIV(SD), .SETUP_CYC(SU), .GAP_CYC(GP)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .ssel(ssel), .sck(sck),
    .mosi(mosi), .miso(miso), .out_data(out_data), .out_mic(out_mic),
    .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int chk_cnt = 0, pass_cnt = 0;
  bit rnd_ready = 1'b0;

  logic [7:0] slv [0:NM];
  logic sck_q = 1'b0, ssel_q = 1'b1;
  int rise_cnt = 0, rise_total = 0, last_rise_cyc = 0;
  int fall_cyc = 0, ssel_rise_cyc = 0, low_len = 0, gap_len = 0, fall_total = 0, fd_cnt = 0;
  logic [7:0] q_data[$];
  int         q_mic[$];
  logic       q_last[$];
  logic       cap_bits[$];
  int         rise_q[$];

  // Slave model and monitor, evaluated mid-cycle.
  always @(negedge clk) begin
    if (ssel_q && !ssel) begin
      rise_cnt = 0; fall_cyc = cyc; gap_len = cyc - ssel_rise_cyc; fall_total++;
    end
    if (!ssel_q && ssel) begin
      ssel_rise_cyc = cyc; low_len = cyc - fall_cyc;
    end
    if (!sck_q && sck) begin
      cap_bits.push_back(miso); rise_q.push_back(cyc);
      rise_cnt++; rise_total++; last_rise_cyc = cyc;
    end
    if (!ssel && !sck && rise_cnt < 8 * (NM + 1)) miso = slv[rise_cnt / 8][7 - rise_cnt % 8];
    if (out_valid && out_ready) begin
      q_data.push_back(out_data); q_mic.push_back(int'(out_mic)); q_last.push_back(out_last);
    end
    if (frame_done) fd_cnt++;
    sck_q = sck; ssel_q = ssel;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    q_data.delete(); q_mic.delete(); q_last.delete(); cap_bits.delete(); rise_q.delete();
  endtask

  task automatic pulse_start(output int t0);
    start = 1'b1; t0 = cyc;
    step(1);
    start = 1'b0;
  endtask

  task automatic wait_fd(input int target, input int bound, output bit ok);
    int n = 0;
    while (fd_cnt < target && n < bound) begin
      if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
      step(1);
      n++;
    end
    ok = (fd_cnt >= target);
  endtask

  task automatic load_counting_slave();
    slv[0] = 8'hAA;
    for (int i = 0; i < NM; i++) slv[i + 1] = 8'(i);
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; out_ready = 1'b1;
    step(3);
    chk_cnt++; if (ssel !== 1'b1) $display("FAIL reset_ssel got %b want 1", ssel); else pass_cnt++;
    chk_cnt++; if (sck !== 1'b0) $display("FAIL reset_sck got %b want 0", sck); else pass_cnt++;
    chk_cnt++; if (mosi !== 1'b0) $display("FAIL reset_mosi got %b want 0", mosi); else pass_cnt++;
    chk_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else pass_cnt++;
    chk_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", out_valid); else pass_cnt++;
    chk_cnt++; if (out_last !== 1'b0) $display("FAIL reset_last got %b want 0", out_last); else pass_cnt++;
    chk_cnt++; if (out_data !== 8'h00) $display("FAIL reset_data got %h want 00", out_data); else pass_cnt++;
    chk_cnt++; if (out_mic !== '0) $display("FAIL reset_mic got %0d want 0", out_mic); else pass_cnt++;
    chk_cnt++; if (frame_done !== 1'b0) $display("FAIL reset_done got %b want 0", frame_done); else pass_cnt++;
    rst = 1'b0;
    step(4);
    chk_cnt++; if (ssel !== 1'b1 || busy !== 1'b0) $display("FAIL idle_hold ssel=%b busy=%b want 1/0", ssel, busy); else pass_cnt++;
  endtask

  task automatic test_nominal();
    int t0, fd0, bad;
    bit ok;
    load_counting_slave(); clear_mon(); fd0 = fd_cnt; out_ready = 1'b1;
    pulse_start(t0);
    chk_cnt++; if (busy !== 1'b1 || ssel !== 1'b0) $display("FAIL nom_start busy=%b ssel=%b want 1/0", busy, ssel); else pass_cnt++;
    wait_fd(fd0 + 1, 3000, ok);
    chk_cnt++; if (!ok) $display("FAIL nom_timeout frame_done count %0d want %0d", fd_cnt, fd0 + 1); else pass_cnt++;
    step(GP + 4);
    chk_cnt++; if (fall_cyc !== t0 + 1) $display("FAIL nom_ssel_fall got %0d want %0d", fall_cyc, t0 + 1); else pass_cnt++;
    chk_cnt++; if (rise_q.size() < 9 || rise_q[0] !== t0 + 1 + SU + SD)
      $display("FAIL nom_first_rise got %0d want %0d", (rise_q.size() > 0) ? rise_q[0] : -1, t0 + 1 + SU + SD); else pass_cnt++;
    chk_cnt++; if (rise_q.size() < 9 || rise_q[1] - rise_q[0] !== 2 * SD)
      $display("FAIL nom_sck_period got %0d want %0d", (rise_q.size() > 1) ? rise_q[1] - rise_q[0] : -1, 2 * SD); else pass_cnt++;
    chk_cnt++; if (rise_q.size() < 9 || rise_q[8] - rise_q[7] !== 2 * SD + 1)
      $display("FAIL nom_byte_slot got %0d want %0d", (rise_q.size() > 8) ? rise_q[8] - rise_q[7] : -1, 2 * SD + 1); else pass_cnt++;
    chk_cnt++; if (low_len !== SU + (NM + 1) * SLOT + 1)
      $display("FAIL nom_ssel_low got %0d want %0d", low_len, SU + (NM + 1) * SLOT + 1); else pass_cnt++;
    chk_cnt++; if (q_data.size() !== NM) $display("FAIL nom_count got %0d want %0d", q_data.size(), NM); else pass_cnt++;
    for (int i = 0; i < NM && i < q_data.size(); i++) begin
      chk_cnt++;
      if (q_data[i] !== 8'(i) || q_mic[i] != i || q_last[i] !== (i == NM - 1))
        $display("FAIL nom_item%0d got data=%h mic=%0d last=%b want %h/%0d/%b",
                 i, q_data[i], q_mic[i], q_last[i], 8'(i), i, (i == NM - 1));
      else pass_cnt++;
    end
    bad = 0;
    for (int i = 0; i < q_data.size(); i++) if (q_data[i] === 8'hAA) bad++;
    chk_cnt++; if (bad != 0) $display("FAIL nom_dummy_leak got %0d AA bytes want 0", bad); else pass_cnt++;
    chk_cnt++; if (fd_cnt - fd0 !== 1) $display("FAIL nom_done_pulses got %0d want 1", fd_cnt - fd0); else pass_cnt++;
    chk_cnt++; if (busy !== 1'b0 || ssel !== 1'b1) $display("FAIL nom_idle busy=%b ssel=%b want 0/1", busy, ssel); else pass_cnt++;
  endtask

  task automatic test_backpressure();
    int t0, fd0, n, a, r0, bad_d, bad_sck, bad_ssel, bad_v, bad;
    bit ok;
    load_counting_slave(); clear_mon(); fd0 = fd_cnt; out_ready = 1'b1;
    pulse_start(t0);
    n = 0;
    while (!(out_valid === 1'b1 && int'(out_mic) == 3) && n < 3000) begin step(1); n++; end
    chk_cnt++; if (n >= 3000) $display("FAIL bp_find_mic3 got timeout want mic 3 valid"); else pass_cnt++;
    out_ready = 1'b0;
    bad_d = 0; bad_sck = 0; bad_ssel = 0; bad_v = 0;
    for (int i = 0; i < 50; i++) begin
      if (out_data !== 8'h03) bad_d++;
      if (sck !== 1'b0) bad_sck++;
      if (ssel !== 1'b0) bad_ssel++;
      if (out_valid !== 1'b1) bad_v++;
      step(1);
    end
    chk_cnt++; if (bad_d != 0) $display("FAIL bp_data_stable got %0d bad cycles want 0", bad_d); else pass_cnt++;
    chk_cnt++; if (bad_sck != 0) $display("FAIL bp_sck_low got %0d bad cycles want 0", bad_sck); else pass_cnt++;
    chk_cnt++; if (bad_ssel != 0) $display("FAIL bp_ssel_low got %0d bad cycles want 0", bad_ssel); else pass_cnt++;
    chk_cnt++; if (bad_v != 0) $display("FAIL bp_valid_held got %0d bad cycles want 0", bad_v); else pass_cnt++;
    out_ready = 1'b1; a = cyc; r0 = rise_total;
    n = 0;
    while (rise_total == r0 && n < 100) begin step(1); n++; end
    chk_cnt++; if (last_rise_cyc !== a + SD) $display("FAIL bp_resume got rise at %0d want %0d", last_rise_cyc, a + SD); else pass_cnt++;
    wait_fd(fd0 + 1, 3000, ok);
    chk_cnt++; if (!ok) $display("FAIL bp_timeout frame_done count %0d want %0d", fd_cnt, fd0 + 1); else pass_cnt++;
    step(GP + 4);
    bad = (q_data.size() == NM) ? 0 : 1;
    for (int i = 0; i < NM && i < q_data.size(); i++)
      if (q_data[i] !== 8'(i) || q_mic[i] != i) bad++;
    chk_cnt++; if (bad != 0) $display("FAIL bp_sequence got %0d errors (%0d items) want 0", bad, q_data.size()); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int t0, fd0, falls0, n, bad;
    bit ok;
    load_counting_slave(); clear_mon(); fd0 = fd_cnt; out_ready = 1'b1;
    pulse_start(t0);
    n = 0;
    while (!(out_valid === 1'b1 && int'(out_mic) == 10) && n < 3000) begin step(1); n++; end
    chk_cnt++; if (n >= 3000) $display("FAIL rstmid_find_mic10 got timeout want mic 10 valid"); else pass_cnt++;
    rst = 1'b1;
    step(1);
    chk_cnt++; if (ssel !== 1'b1) $display("FAIL rstmid_ssel got %b want 1", ssel); else pass_cnt++;
    chk_cnt++; if (sck !== 1'b0) $display("FAIL rstmid_sck got %b want 0", sck); else pass_cnt++;
    chk_cnt++; if (out_valid !== 1'b0) $display("FAIL rstmid_valid got %b want 0", out_valid); else pass_cnt++;
    chk_cnt++; if (busy !== 1'b0) $display("FAIL rstmid_busy got %b want 0", busy); else pass_cnt++;
    rst = 1'b0;
    step(GP + 10);
    chk_cnt++; if (fd_cnt !== fd0) $display("FAIL rstmid_no_done got %0d pulses want 0", fd_cnt - fd0); else pass_cnt++;
    clear_mon(); falls0 = fall_total;
    pulse_start(t0);
    wait_fd(fd0 + 1, 3000, ok);
    chk_cnt++; if (!ok) $display("FAIL rstmid_timeout frame_done count %0d want %0d", fd_cnt, fd0 + 1); else pass_cnt++;
    step(GP + 4);
    bad = (q_data.size() == NM) ? 0 : 1;
    for (int i = 0; i < NM && i < q_data.size(); i++)
      if (q_data[i] !== 8'(i) || q_mic[i] != i || q_last[i] !== (i == NM - 1)) bad++;
    chk_cnt++; if (bad != 0) $display("FAIL rstmid_refill got %0d errors (%0d items) want 0", bad, q_data.size()); else pass_cnt++;
    chk_cnt++; if (fall_total - falls0 !== 1) $display("FAIL rstmid_frames got %0d ssel falls want 1", fall_total - falls0); else pass_cnt++;
  endtask

  task automatic test_start_handling();
    int t0, fd0, falls0, n, r0;
    bit ok;
    load_counting_slave(); clear_mon(); fd0 = fd_cnt; falls0 = fall_total; out_ready = 1'b1;
    pulse_start(t0);
    r0 = rise_total; n = 0;
    while (rise_total < r0 + 4 && n < 200) begin step(1); n++; end
    start = 1'b1;
    step(1);
    start = 1'b0;
    wait_fd(fd0 + 1, 3000, ok);
    step(GP + 6);
    chk_cnt++; if (fd_cnt - fd0 !== 1) $display("FAIL ignore_done got %0d pulses want 1", fd_cnt - fd0); else pass_cnt++;
    chk_cnt++; if (fall_total - falls0 !== 1) $display("FAIL ignore_frames got %0d ssel falls want 1", fall_total - falls0); else pass_cnt++;
    chk_cnt++; if (q_data.size() !== NM) $display("FAIL ignore_count got %0d want %0d", q_data.size(), NM); else pass_cnt++;

    clear_mon(); fd0 = fd_cnt; falls0 = fall_total;
    start = 1'b1;
    wait_fd(fd0 + 2, 5000, ok);
    start = 1'b0;
    chk_cnt++; if (!ok) $display("FAIL b2b_timeout frame_done count %0d want %0d", fd_cnt, fd0 + 2); else pass_cnt++;
    step(GP + 6);
    chk_cnt++; if (gap_len !== GP) $display("FAIL b2b_gap got %0d want %0d", gap_len, GP); else pass_cnt++;
    chk_cnt++; if (fall_total - falls0 !== 2) $display("FAIL b2b_frames got %0d ssel falls want 2", fall_total - falls0); else pass_cnt++;
    chk_cnt++; if (q_data.size() !== 2 * NM) $display("FAIL b2b_count got %0d want %0d", q_data.size(), 2 * NM); else pass_cnt++;
  endtask

  task automatic test_random();
    int t0, fd0, bad;
    bit ok;
    logic [7:0] e;
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i <= NM; i++) slv[i] = 8'($urandom_range(0, 255));
      clear_mon(); fd0 = fd_cnt; out_ready = 1'b1;
      pulse_start(t0);
      rnd_ready = 1'b1;
      wait_fd(fd0 + 1, 8000, ok);
      rnd_ready = 1'b0; out_ready = 1'b1;
      step(GP + 4);
      chk_cnt++; if (cap_bits.size() !== 8 * (NM + 1))
        $display("FAIL rnd%0d_bits got %0d want %0d", f, cap_bits.size(), 8 * (NM + 1)); else pass_cnt++;
      chk_cnt++; if (q_data.size() !== NM) $display("FAIL rnd%0d_count got %0d want %0d", f, q_data.size(), NM); else pass_cnt++;
      bad = 0;
      for (int k = 0; k < NM; k++) begin
        e = '0;
        if (cap_bits.size() >= 8 * (NM + 1))
          for (int b = 0; b < 8; b++) e = {e[6:0], cap_bits[8 * (k + 1) + b]};
        if (k >= q_data.size()) bad++;
        else if (q_data[k] !== e || q_mic[k] != k || q_last[k] !== (k == NM - 1)) bad++;
      end
      chk_cnt++; if (bad != 0) $display("FAIL rnd%0d_bytes got %0d wrong bytes want 0", f, bad); else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_backpressure();
    test_reset_mid();
    test_start_handling();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1);
  end

endmodule
